// File: rtl/alu_result_stage_if.sv
// Result-stage handshake bundle: producer side (z/in_valid/in_ready) and
// consumer side (out_* / out_ready / out_count).
interface alu_result_stage_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] z;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_count;

    modport slave (
        input  z, in_valid, out_ready,
        output in_ready, out_data, out_zero, out_neg, out_valid, out_count
    );

    modport master (
        output z, in_valid, out_ready,
        input  in_ready, out_data, out_zero, out_neg, out_valid, out_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry result FIFO carrying the word plus zero/negative flags; 1-cycle latency.
// Backpressure: in_ready drops when both entries are full; all outputs are registered state.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_stage_if.slave bus
);
    localparam int EW = WIDTH + 2;

    logic [EW-1:0] mem [2];
    logic [EW-1:0] head;
    logic [EW-1:0] z_ent;
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    occ;
    logic [1:0]    occ_nxt;
    logic [15:0]   cnt;
    logic          push;
    logic          pop;

    assign push  = bus.in_valid && (occ != DEPTH[1:0]);
    assign pop   = bus.out_ready && (occ != 2'd0);
    // Flags are captured from z here so the stored entry never needs recomputation.
    assign z_ent = {bus.z[WIDTH-1], (bus.z == '0), bus.z};

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= z_ent;
        end
    end

    // The head is a dedicated register so outputs hold their last value once empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 16'd0;
            head   <= {1'b0, 1'b1, {WIDTH{1'b0}}};
        end else begin
            occ <= occ_nxt;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                cnt    <= cnt + 16'd1;
            end
            if (occ == 2'd0 && push) begin
                head <= z_ent;
            end else if (pop && occ == 2'd2) begin
                head <= mem[~rd_ptr];
            end else if (pop && push) begin
                head <= z_ent;
            end
        end
    end

    assign bus.in_ready  = (occ != DEPTH[1:0]);
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = head[WIDTH-1:0];
    assign bus.out_zero  = head[WIDTH];
    assign bus.out_neg   = head[WIDTH+1];
    assign bus.out_count = cnt;
endmodule
